// File: rtl/norm_shift_count_pkg.sv
// Shared FPU constants for the normalization shift counter.
// FSM encodings stay plain 2-bit constants so older netlists keep the same state codes.
package norm_shift_count_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [2:0] MAX_SHIFT = 3'd7;

  typedef enum logic [2:0] {
    STOP_NONE  = 3'd0,
    STOP_ZERO  = 3'd1,
    STOP_MSB   = 3'd2,
    STOP_GUARD = 3'd3,
    STOP_MAX   = 3'd4
  } stop_e;

endpackage

// File: rtl/norm_shift_count_if.sv
// Handshake and data bundle between the adder controller (master) and the
// normalization shift counter (slave).
interface norm_shift_count_if #(
  parameter int SW = 26,
  parameter int W  = 8
);
  logic          start;
  logic [SW-1:0] Mant_in;
  logic [W-1:0]  Exp_in;
  logic [SW-1:0] Mant_out;
  logic [2:0]    Shift_cnt;
  logic          busy;
  logic          ready;
  logic          zero_flag;
  logic          exp_lim;

  modport master (
    output start, Mant_in, Exp_in,
    input  Mant_out, Shift_cnt, busy, ready, zero_flag, exp_lim
  );

  modport slave (
    input  start, Mant_in, Exp_in,
    output Mant_out, Shift_cnt, busy, ready, zero_flag, exp_lim
  );
endinterface

// File: rtl/norm_shift_count.sv
// Left-normalizes a significand one bit per cycle, counting up to 7 shifts and
// never shifting past the current exponent; Shift_cnt feeds the exponent subtractor.
module norm_shift_count
  import norm_shift_count_pkg::*;
#(
  parameter int SW = 26,
  parameter int W  = 8
) (
  input logic               clk,
  input logic               rst,
  norm_shift_count_if.slave bus
);

  logic [1:0]    state_r;
  logic [SW-1:0] mant_r;
  logic [W-1:0]  exp_r;
  logic [2:0]    cnt_r;
  logic          busy_r;
  logic          ready_r;
  logic          zero_r;
  logic          lim_r;
  logic [W-1:0]  cnt_ext_s;
  stop_e         stop_s;

  // Zero-extend the count so the guard compare cannot let Exp_in - Shift_cnt wrap.
  assign cnt_ext_s = W'(cnt_r);

  // Stop-condition priority: zero, normalized, exponent guard, shift limit.
  always_comb begin
    stop_s = STOP_NONE;
    if (mant_r == {SW{1'b0}}) begin
      stop_s = STOP_ZERO;
    end else if (mant_r[SW-1] == 1'b1) begin
      stop_s = STOP_MSB;
    end else if (cnt_ext_s == exp_r) begin
      stop_s = STOP_GUARD;
    end else if (cnt_r == MAX_SHIFT) begin
      stop_s = STOP_MAX;
    end else begin
      stop_s = STOP_NONE;
    end
  end

  // FSM and datapath; outputs come straight from these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mant_r  <= {SW{1'b0}};
      exp_r   <= {W{1'b0}};
      cnt_r   <= 3'd0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      zero_r  <= 1'b0;
      lim_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            mant_r  <= bus.Mant_in;
            exp_r   <= bus.Exp_in;
            cnt_r   <= 3'd0;
            zero_r  <= 1'b0;
            lim_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (stop_s == STOP_NONE) begin
            mant_r <= {mant_r[SW-2:0], 1'b0};
            cnt_r  <= cnt_r + 3'd1;
          end else begin
            zero_r  <= (stop_s == STOP_ZERO);
            lim_r   <= (stop_s == STOP_GUARD);
            ready_r <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Mant_out  = mant_r;
  assign bus.Shift_cnt = cnt_r;
  assign bus.busy      = busy_r;
  assign bus.ready     = ready_r;
  assign bus.zero_flag = zero_r;
  assign bus.exp_lim   = lim_r;

endmodule

// File: doc/norm_shift_count.md
NORM_SHIFT_COUNT -- requirements
Module: Norm_Shift_Count

Interface
REQ-001 Parameter SW, default 26, significand width in bits (hidden bit plus fraction plus guard).
REQ-002 Parameter W, default 8, exponent width in bits; set to 11 for double precision.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  load request; sampled only in IDLE.
REQ-006 Mant_in  input  SW  unnormalized significand from the adder.
REQ-007 Exp_in  input  W  current biased exponent, used as the shift guard.
REQ-008 Mant_out  output  SW  left-normalized significand.
REQ-009 Shift_cnt  output  3  shifts applied; drives the 3-bit B operand of the downstream exponent subtractor.
REQ-010 busy  output  1  high in SHIFT and DONE.
REQ-011 ready  output  1  one-cycle pulse; Mant_out, Shift_cnt and the flags are valid.
REQ-012 zero_flag  output  1  the loaded significand was all zeros.
REQ-013 exp_lim  output  1  shifting stopped because Shift_cnt reached Exp_in.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1, the block SHALL register Mant_in and Exp_in, clear Shift_cnt and the flags, and enter SHIFT.
REQ-016 In IDLE with start=0, the block SHALL hold all outputs.
REQ-017 In SHIFT, the stop conditions SHALL be evaluated in this priority:
  - mantissa==0: set zero_flag and go to DONE;
  - MSB==1: go to DONE;
  - Shift_cnt==Exp_in (guard): set exp_lim and go to DONE;
  - Shift_cnt==7: go to DONE.
REQ-018 If no stop condition holds in SHIFT, the block SHALL shift the mantissa left by one, zero-fill the LSB and increment Shift_cnt, all in the same cycle.
REQ-019 The exponent guard SHALL compare Shift_cnt, zero-extended to W bits, with Exp_in, so Exp_in-Shift_cnt never wraps below zero.
REQ-020 In DONE, the block SHALL assert ready for exactly one cycle and return to IDLE.
REQ-021 Mant_out, Shift_cnt and the flags SHALL hold their values until the next accepted start.
REQ-022 Latency SHALL be n+2 cycles from the start edge to the ready cycle, where n is the number of shifts performed (0..7).
REQ-023 start SHALL be ignored while busy=1; there is no queueing.
REQ-024 If start=1 in the same cycle that ready=1, it SHALL be ignored because the FSM is not yet in IDLE.
REQ-025 Shift_cnt SHALL never exceed 7; a significand needing more than 7 shifts SHALL be reissued by the controller.

Reset
REQ-026 rst=1 SHALL force the FSM to IDLE asynchronously.
REQ-027 rst=1 SHALL clear Mant_out, Shift_cnt, busy, ready, zero_flag and exp_lim to 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no ready pulse.
REQ-029 The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-030 State encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the maximum shift constant 7 SHALL live in the shared FPU package.
REQ-031 The block SHALL be a single module with no sub-modules.
REQ-032 Shift_cnt SHALL connect directly to the B port of the existing exponent subtractor; the subtractor is not instantiated inside this block.

Verification
REQ-033 SW=8, Mant_in=8'h10, Exp_in=20, start -> Mant_out=8'h80, Shift_cnt=3, ready 5 cycles after start, flags 0.
REQ-034 Mant_in=8'h80 -> Shift_cnt=0, ready 2 cycles after start, Mant_out=8'h80.
REQ-035 Mant_in=8'h01, Exp_in=100 -> Shift_cnt=7, Mant_out=8'h80, exp_lim=0, ready 9 cycles after start.
REQ-036 Mant_in=8'h01, Exp_in=2 -> Shift_cnt=2, Mant_out=8'h04, exp_lim=1.
REQ-037 Mant_in=0 -> zero_flag=1, Shift_cnt=0; a second start while busy produces no extra ready pulse.
REQ-038 rst asserted during SHIFT -> all outputs 0 immediately, no ready; the next start completes normally.
